// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave.
// The owner holds the bus for its whole cyc (locked burst). There is one
// dead cycle between owners. A wait-state watchdog forces an error back
// to the owner when the slave stalls.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 128,
  parameter int SEL_WIDTH   = DATA_WIDTH/8,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [NUM_MASTERS-1:0]            m_rty_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  output logic [SEL_WIDTH-1:0]              s_sel_o,
  output logic                              s_we_o,
  output logic                              s_stb_o,
  output logic                              s_cyc_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i,
  input  logic                              s_err_i,
  input  logic                              s_rty_i,
  output logic [NUM_MASTERS-1:0]            grant_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 r_state;
  logic [IW-1:0]          r_owner;
  logic [IW-1:0]          r_last;
  logic [CW-1:0]          r_cnt;
  logic [NUM_MASTERS-1:0] r_grant;

  logic          w_owned, w_own_cyc, w_own_stb, w_stb_raw, w_term, w_tmo, w_route;
  logic          w_found;
  logic [IW-1:0] w_next;

  // Reset is folded into the combinational path.
  // Because of this, a transfer cut by rst never sees a termination pulse.
  assign w_owned   = (r_state == OWNED) && !rst;
  assign w_own_cyc = m_cyc_i[r_owner];
  assign w_own_stb = m_stb_i[r_owner];
  assign w_stb_raw = w_owned && w_own_cyc && w_own_stb;
  assign w_term    = s_ack_i | s_err_i | s_rty_i;
  // A slave termination in the timeout cycle wins over the forced error.
  assign w_tmo     = (TIMEOUT != 0) && w_stb_raw && !w_term && (r_cnt == TO_V);
  assign w_route   = w_owned && w_own_cyc && !w_tmo;

  assign s_adr_o = m_adr_i[int'(r_owner)*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_dat_o = m_dat_i[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];
  assign s_sel_o = m_sel_i[int'(r_owner)*SEL_WIDTH +: SEL_WIDTH];
  assign s_we_o  = w_owned && m_we_i[r_owner];
  assign s_cyc_o = w_route;
  assign s_stb_o = w_stb_raw && !w_tmo;
  assign m_dat_o = s_dat_i;
  assign grant_o = r_grant;

  // Route slave terminations to the owner only; a watchdog expiry becomes an error.
  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (w_route) begin
      m_ack_o[r_owner] = s_ack_i;
      m_err_o[r_owner] = s_err_i;
      m_rty_o[r_owner] = s_rty_i;
    end
    if (w_tmo) m_err_o[r_owner] = 1'b1;
  end

  // Round-robin pick: the first requester after last_owner, with wrap-around.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_next  = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = int'(r_last) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!w_found && m_cyc_i[idx]) begin
        w_found = 1'b1;
        w_next  = IW'(idx);
      end
    end
  end

  // Ownership FSM: owner, last owner, grant vector and watchdog counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= IW'(NUM_MASTERS - 1);
      r_cnt   <= '0;
      r_grant <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_found) begin
            r_state         <= OWNED;
            r_owner         <= w_next;
            r_grant         <= '0;
            r_grant[w_next] <= 1'b1;
          end
        end
        OWNED: begin
          if (!w_own_cyc || w_tmo) begin
            r_state <= IDLE;
            r_last  <= r_owner;
            r_grant <= '0;
            r_cnt   <= '0;
          end else if (w_stb_raw && !w_term) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter (4 masters, watchdog of 4 wait cycles).
// Directed scenarios come first, then a randomized run.
// The randomized run is scored against a cycle-level ownership model.
module tb_wb_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int SW = DW/8;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*AW-1:0] m_adr = '0;
  logic [N*DW-1:0] m_dat = '0;
  logic [N*SW-1:0] m_sel = '0;
  logic [N-1:0]    m_we = '0, m_stb = '0, m_cyc = '0;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, m_rty_o, grant_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [SW-1:0]   s_sel_o;
  logic            s_we_o, s_stb_o, s_cyc_o;
  logic [DW-1:0]   s_dat = '0;
  logic            s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;

  int checks = 0;
  int errors = 0;

  wb_rr_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                  .SEL_WIDTH(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_we_i(m_we), .m_stb_i(m_stb), .m_cyc_i(m_cyc),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", grant_o); end
    checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin errors++; $display("FAIL reset_cyc got %b%b exp 00", s_cyc_o, s_stb_o); end
    checks++; if ((m_ack_o | m_err_o | m_rty_o) !== 4'b0000) begin errors++; $display("FAIL reset_term got %b exp 0000", m_ack_o | m_err_o | m_rty_o); end
  endtask

  task automatic test_first_grant();
    do_reset();
    for (int i = 0; i < N; i++) m_adr[i*AW +: AW] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    m_cyc = 4'b1010; m_stb = 4'b1010;
    tick(); settle();
    checks++; if (grant_o !== 4'b0010) begin errors++; $display("FAIL first_grant got %b exp 0010", grant_o); end
    checks++; if (s_adr_o !== 32'h1101_0101) begin errors++; $display("FAIL first_adr got %h exp 11010101", s_adr_o); end
    checks++; if (s_cyc_o !== 1'b1) begin errors++; $display("FAIL first_cyc got %b exp 1", s_cyc_o); end
  endtask

  task automatic test_round_robin();
    int order[$];
    int ackcnt[N];
    int gap, o;
    logic [N-1:0] g, prev_g;
    logic done;
    do_reset();
    foreach (ackcnt[i]) ackcnt[i] = 0;
    m_cyc = 4'b1111; m_stb = 4'b1111;
    prev_g = '0; gap = 0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      tick();
      g = grant_o;
      m_cyc = 4'b1111; m_stb = 4'b1111; s_ack = 1'b0;
      if (g == '0) begin
        gap++;
      end else begin
        o = 0;
        for (int i = 0; i < N; i++) if (g[i]) o = i;
        if (prev_g == '0) begin
          order.push_back(o);
          if (order.size() > 1) begin
            checks++; if (gap != 1) begin errors++; $display("FAIL rr_gap got %0d exp 1", gap); end
          end
          gap = 0;
          if (order.size() == 5) done = 1'b1;
        end
        if (!done) begin
          if (ackcnt[o] == 2) begin
            m_cyc[o] = 1'b0; m_stb[o] = 1'b0; ackcnt[o] = 0;
          end else begin
            s_ack = 1'b1;
            settle();
            checks++; if (m_ack_o !== g) begin errors++; $display("FAIL rr_ack got %b exp %b", m_ack_o, g); end
            ackcnt[o]++;
          end
        end
      end
      prev_g = g;
    end
    s_ack = 1'b0;
    checks++;
    if (order.size() != 5) begin
      errors++; $display("FAIL rr_count got %0d exp 5", order.size());
    end else begin
      for (int k = 0; k < 5; k++)
        if (order[k] != (k % N)) begin errors++; $display("FAIL rr_order[%0d] got %0d exp %0d", k, order[k], k % N); end
    end
  endtask

  task automatic test_no_preempt();
    do_reset();
    m_cyc = 4'b0100; m_stb = 4'b0100;
    tick();
    m_cyc = 4'b0101; m_stb = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      s_ack = 1'b1; settle();
      checks++; if (grant_o !== 4'b0100 || m_ack_o !== 4'b0100) begin errors++; $display("FAIL nopre_ack got g=%b ack=%b exp 0100/0100", grant_o, m_ack_o); end
      tick();
    end
    s_ack = 1'b0;
    tick(); settle();
    checks++; if (grant_o !== 4'b0100 || m_ack_o !== 4'b0000) begin errors++; $display("FAIL nopre_hold got g=%b ack=%b exp 0100/0000", grant_o, m_ack_o); end
    tick();
    m_cyc = 4'b0001; m_stb = 4'b0001; settle();
    checks++; if (grant_o !== 4'b0100 || s_cyc_o !== 1'b0) begin errors++; $display("FAIL nopre_rel got g=%b cyc=%b exp 0100/0", grant_o, s_cyc_o); end
    tick(); settle();
    checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL nopre_idle got %b exp 0000", grant_o); end
    tick(); settle();
    checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL nopre_next got %b exp 0001", grant_o); end
  endtask

  task automatic test_timeout();
    do_reset();
    m_cyc = 4'b0010; m_stb = 4'b0010;
    tick();
    for (int k = 0; k < TO; k++) begin
      settle();
      checks++; if (m_err_o !== 4'b0000 || s_stb_o !== 1'b1) begin errors++; $display("FAIL tmo_wait%0d got err=%b stb=%b exp 0000/1", k, m_err_o, s_stb_o); end
      tick();
    end
    settle();
    checks++; if (m_err_o !== 4'b0010 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin errors++; $display("FAIL tmo_err got err=%b cyc=%b stb=%b exp 0010/0/0", m_err_o, s_cyc_o, s_stb_o); end
    tick();
    m_cyc = '0; m_stb = '0; settle();
    checks++; if (grant_o !== 4'b0000 || m_err_o !== 4'b0000) begin errors++; $display("FAIL tmo_after got g=%b err=%b exp 0000/0000", grant_o, m_err_o); end
    // Slave answering in the expiry cycle takes precedence.
    do_reset();
    m_cyc = 4'b0010; m_stb = 4'b0010;
    tick();
    for (int k = 0; k < TO; k++) tick();
    s_ack = 1'b1; settle();
    checks++; if (m_ack_o !== 4'b0010 || m_err_o !== 4'b0000 || s_cyc_o !== 1'b1) begin errors++; $display("FAIL tmo_race got ack=%b err=%b cyc=%b exp 0010/0000/1", m_ack_o, m_err_o, s_cyc_o); end
    tick();
    s_ack = 1'b0; settle();
    checks++; if (grant_o !== 4'b0010 || m_err_o !== 4'b0000) begin errors++; $display("FAIL tmo_race_hold got g=%b err=%b exp 0010/0000", grant_o, m_err_o); end
  endtask

  task automatic test_release_same_cycle();
    do_reset();
    m_cyc = 4'b0010; m_stb = 4'b0010;
    tick();
    m_cyc = '0; m_stb = '0;
    tick();
    m_cyc = 4'b1000; m_stb = 4'b1000;
    tick(); settle();
    checks++; if (grant_o !== 4'b1000) begin errors++; $display("FAIL rel_own3 got %b exp 1000", grant_o); end
    m_cyc = 4'b0101; m_stb = 4'b0101; settle();
    checks++; if (grant_o !== 4'b1000 || s_cyc_o !== 1'b0) begin errors++; $display("FAIL rel_drop got g=%b cyc=%b exp 1000/0", grant_o, s_cyc_o); end
    tick(); settle();
    checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL rel_idle got %b exp 0000", grant_o); end
    tick(); settle();
    checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL rel_next got %b exp 0001", grant_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_cyc = 4'b0100; m_stb = 4'b0100;
    tick();
    s_ack = 1'b1; rst = 1'b1; settle();
    checks++; if ((m_ack_o | m_err_o) !== 4'b0000) begin errors++; $display("FAIL rstmid_term got %b exp 0000", m_ack_o | m_err_o); end
    tick();
    rst = 1'b0; s_ack = 1'b0; m_cyc = 4'b0101; m_stb = 4'b0101; settle();
    checks++; if (grant_o !== 4'b0000 || s_cyc_o !== 1'b0) begin errors++; $display("FAIL rstmid_idle got g=%b cyc=%b exp 0000/0", grant_o, s_cyc_o); end
    tick(); settle();
    checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL rstmid_next got %b exp 0001", grant_o); end
  endtask

  // Model: owner index (-1 when idle), last owner, and the count of
  // consecutive strobed cycles the slave has left unanswered.
  task automatic test_random();
    int mo, ml, mw, nmo, nml, nmw, c;
    logic own_cyc, own_stb, term, tmo, live, dead;
    logic [N-1:0] oh, e_grant, e_ack, e_err, e_rty;
    logic [N-1:0] cyc_st;
    do_reset();
    mo = -1; ml = N - 1; mw = 0;
    cyc_st = '0;
    for (int it = 0; it < 1500; it++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) cyc_st[i] = ~cyc_st[i];
        m_adr[i*AW +: AW] = $urandom;
        m_sel[i*SW +: SW] = 16'($urandom);
        m_dat[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
      end
      m_cyc = cyc_st;
      m_stb = cyc_st & 4'($urandom);
      m_we  = 4'($urandom);
      dead  = ((it / 50) % 4) == 3;
      s_ack = !dead && ($urandom_range(0, 2) == 0);
      s_err = !dead && ($urandom_range(0, 15) == 0);
      s_rty = !dead && ($urandom_range(0, 15) == 0);
      s_dat = {$urandom, $urandom, $urandom, $urandom};
      settle();
      e_grant = '0; e_ack = '0; e_err = '0; e_rty = '0;
      oh = '0; own_cyc = 1'b0; own_stb = 1'b0; tmo = 1'b0; live = 1'b0;
      term = s_ack | s_err | s_rty;
      if (mo >= 0) begin
        oh[mo] = 1'b1;
        e_grant = oh;
        own_cyc = m_cyc[mo];
        own_stb = m_stb[mo];
        tmo  = own_cyc && own_stb && !term && (mw == TO);
        live = own_cyc && !tmo;
        if (live && s_ack) e_ack = oh;
        if ((live && s_err) || tmo) e_err = oh;
        if (live && s_rty) e_rty = oh;
      end
      checks++; if (grant_o !== e_grant) begin errors++; $display("FAIL rnd_grant it=%0d got %b exp %b", it, grant_o, e_grant); end
      checks++; if (s_cyc_o !== live || s_stb_o !== (live && own_stb)) begin errors++; $display("FAIL rnd_cycstb it=%0d got %b%b exp %b%b", it, s_cyc_o, s_stb_o, live, live && own_stb); end
      checks++; if (m_ack_o !== e_ack || m_err_o !== e_err || m_rty_o !== e_rty) begin errors++; $display("FAIL rnd_term it=%0d got %b/%b/%b exp %b/%b/%b", it, m_ack_o, m_err_o, m_rty_o, e_ack, e_err, e_rty); end
      checks++; if (m_dat_o !== s_dat) begin errors++; $display("FAIL rnd_rdata it=%0d got %h exp %h", it, m_dat_o, s_dat); end
      if (live) begin
        checks++;
        if (s_adr_o !== m_adr[mo*AW +: AW] || s_dat_o !== m_dat[mo*DW +: DW] ||
            s_sel_o !== m_sel[mo*SW +: SW] || s_we_o !== m_we[mo]) begin
          errors++; $display("FAIL rnd_fwd it=%0d got adr=%h we=%b exp adr=%h we=%b", it, s_adr_o, s_we_o, m_adr[mo*AW +: AW], m_we[mo]);
        end
      end
      nmo = mo; nml = ml; nmw = 0;
      if (mo < 0) begin
        for (int k = 1; k <= N && nmo < 0; k++) begin
          c = (ml + k) % N;
          if (m_cyc[c]) nmo = c;
        end
      end else if (!own_cyc || tmo) begin
        nml = mo; nmo = -1;
      end else if (own_stb && !term) begin
        nmw = mw + 1;
      end
      tick();
      mo = nmo; ml = nml; mw = nmw;
    end
    m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_round_robin();
    test_no_preempt();
    test_timeout();
    test_release_same_cycle();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of requesting Wishbone masters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, bus address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 128, bus data width (one cache line).
REQ-004 SHALL have parameter SEL_WIDTH, default DATA_WIDTH/8, byte-select width.
REQ-005 SHALL have parameter TIMEOUT, default 255, max wait-state cycles before an error is forced; 0 disables the timeout.
REQ-006 SHALL have port clk, input, 1, clock; all state on the rising edge.
REQ-007 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have ports m_adr_i / m_dat_i / m_sel_i, input, NUM_MASTERS x ADDR_WIDTH / DATA_WIDTH / SEL_WIDTH, flattened per-master request fields; master i occupies slice i.
REQ-009 SHALL have ports m_we_i / m_stb_i / m_cyc_i, input, NUM_MASTERS, per-master write enable, strobe and cycle.
REQ-010 SHALL have port m_dat_o, output, DATA_WIDTH, read data broadcast to all masters.
REQ-011 SHALL have ports m_ack_o / m_err_o / m_rty_o, output, NUM_MASTERS, per-master termination.
REQ-012 SHALL have ports s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o, output, widths as the master fields, slave-side request.
REQ-013 SHALL have ports s_dat_i, s_ack_i, s_err_i, s_rty_i, input, DATA_WIDTH/1/1/1, slave-side response.
REQ-014 SHALL have port grant_o, output, NUM_MASTERS, one-hot current owner, all-zero when idle.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and OWNED.
REQ-016 IDLE: if any m_cyc_i is high, SHALL select the first requester found scanning from (last_owner+1) mod NUM_MASTERS upward with wrap-around, register it as owner and enter OWNED on the next edge; arbitration latency is 1 cycle.
REQ-017 IDLE: s_cyc_o, s_stb_o and all m_*_o terminations SHALL be 0.
REQ-018 OWNED: s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o and s_cyc_o SHALL combinationally follow the owner's inputs.
REQ-019 OWNED: s_ack_i, s_err_i and s_rty_i SHALL route combinationally to the owner's bit only; non-owner terminations SHALL be 0.
REQ-020 OWNED: the owner SHALL keep the bus for as long as its m_cyc_i stays high (locked burst); other requests SHALL never preempt.
REQ-021 OWNED: when the owner's m_cyc_i is low, the FSM SHALL return to IDLE on that edge, set last_owner to the owner and drive s_cyc_o low in that cycle; new requests are arbitrated in the following IDLE cycle (one dead cycle minimum between owners).
REQ-022 A request arriving in the same cycle the owner releases SHALL compete in the next IDLE cycle under the updated last_owner.
REQ-023 The timeout counter SHALL increment each OWNED cycle with s_stb_o high and no s_ack_i/s_err_i/s_rty_i, and SHALL clear on any termination, on s_stb_o low, or on leaving OWNED.
REQ-024 When the counter reaches TIMEOUT, the arbiter SHALL assert the owner's m_err_o for exactly one cycle, drive s_cyc_o and s_stb_o low in that cycle and return to IDLE.
REQ-025 If the slave terminates in the same cycle the count reaches TIMEOUT, the slave termination SHALL win and no error SHALL be forced.
REQ-026 m_dat_o SHALL equal s_dat_i at all times.
REQ-027 The arbiter SHALL hold no data; its only state is FSM state, owner, last_owner and the timeout counter.

Reset
REQ-028 On rst, the arbiter SHALL set state IDLE, grant_o 0, last_owner NUM_MASTERS-1 (so master 0 wins first) and the timeout counter 0.
REQ-029 rst asserted mid-transfer SHALL abandon the transfer with no termination pulse to the owner; s_cyc_o SHALL be 0 in the first cycle after the reset edge.

Verification
REQ-030 Reset release, then m_cyc_i=4'b1010 -> one cycle later grant_o=4'b0010 and s_adr_o equals master 1's address.
REQ-031 All four masters hold cyc, each releasing after 2 acks -> grant order is 0,1,2,3,0 with exactly one idle cycle between owners.
REQ-032 Master 2 owns the bus, master 0 requests, slave acks 3 times -> grant stays 4'b0100 until master 2 drops cyc; m_ack_o[0] stays 0 throughout.
REQ-033 TIMEOUT=4, slave never acks -> m_err_o of owner pulses once, 4 stb cycles after the strobe rose, then grant_o=0.
REQ-034 Master 3 owns the bus, master 3 drops cyc while master 0 raises cyc in the same cycle -> next owner is master 0 after one idle cycle, and last_owner=3.
REQ-035 rst asserted during an OWNED cycle with an ack pending -> no m_ack_o/m_err_o pulse, grant_o=0 next cycle, and master 0 wins the next arbitration.
